// File: rtl/gpio_wb_arbiter.sv
// Round-robin arbiter giving two Wishbone classic masters turns on one GPIO slave port,
// with a watchdog that turns a stalled strobe into a one-cycle error.
module gpio_wb_arbiter #(
   parameter int AW      = 1,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic          wb_clk,
   input  logic          wb_rst_n,
   input  logic [AW-1:0] m0_adr_i,
   input  logic [DW-1:0] m0_dat_i,
   input  logic          m0_we_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   output logic [DW-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   input  logic [AW-1:0] m1_adr_i,
   input  logic [DW-1:0] m1_dat_i,
   input  logic          m1_we_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   output logic [DW-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic [AW-1:0] s_adr_o,
   output logic [DW-1:0] s_dat_o,
   output logic          s_we_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   input  logic [DW-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   output logic [1:0]    grant_o,
   output logic [1:0]    dbg_state_o
);

   // Handshake: a master owns the slave from the cycle after its grant registers until it
   // drops cyc; each stb cycle ends on ack or err, and only the owner sees ack/err/dat.
   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDW-1:0] TMO_VAL = WDW'(TIMEOUT);
   localparam logic [WDW-1:0] WD_MAX  = '1;
   localparam logic [WDW-1:0] WD_ONE  = 1;

   state_t         r_state;
   state_t         w_next;
   logic           r_last_grant;
   logic [WDW-1:0] r_wdog;
   logic           w_granted;
   logic           w_sel_stb;
   logic           w_tmo;

   assign w_granted   = (r_state == GNT0) || (r_state == GNT1);
   assign w_sel_stb   = (r_state == GNT0) ? m0_stb_i :
                        (r_state == GNT1) ? m1_stb_i : 1'b0;
   assign w_tmo       = (TIMEOUT != 0) && (r_wdog == TMO_VAL);
   assign dbg_state_o = r_state;

   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         r_state      <= IDLE;
         r_last_grant <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == GNT0 && !m0_cyc_i)
            r_last_grant <= 1'b0;
         else if (r_state == GNT1 && !m1_cyc_i)
            r_last_grant <= 1'b1;
      end
   end

   // Saturating stall counter; the timeout cycle itself reports err, so it also clears here.
   always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n)
         r_wdog <= '0;
      else if (!w_granted || !w_sel_stb || s_ack_i || s_err_i || w_tmo)
         r_wdog <= '0;
      else if (r_wdog != WD_MAX)
         r_wdog <= r_wdog + WD_ONE;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i)
               w_next = r_last_grant ? GNT0 : GNT1;
            else if (m0_cyc_i)
               w_next = GNT0;
            else if (m1_cyc_i)
               w_next = GNT1;
         end
         GNT0:    if (!m0_cyc_i) w_next = IDLE;
         GNT1:    if (!m1_cyc_i) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      grant_o  = 2'b00;
      case (r_state)
         GNT0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~w_tmo;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i | w_tmo;
            grant_o  = 2'b01;
         end
         GNT1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~w_tmo;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i | w_tmo;
            grant_o  = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_gpio_wb_arbiter.sv
// Bench for gpio_wb_arbiter: directed master transfers against a small GPIO-like slave,
// with a response scoreboard plus inline timing checks.
module tb_gpio_wb_arbiter;

   localparam int W = 22;

   logic       clk;
   logic       rst_n;
   logic       m0_adr, m1_adr, m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
   logic [7:0] m0_wd, m1_wd;
   logic [7:0] m0_dat_o, m1_dat_o;
   logic       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic       s_adr_o, s_we_o, s_cyc_o, s_stb_o;
   logic [7:0] s_dat_o, s_dat_i;
   logic       s_ack_i, s_err_i;
   logic [1:0] grant_o, dbg_state;

   logic [7:0] z_m0_dat, z_m1_dat, z_s_dat;
   logic       z_m0_ack, z_m0_err, z_m1_ack, z_m1_err, z_s_adr, z_s_we, z_s_cyc, z_s_stb;
   logic [1:0] z_grant, z_dbg;

   logic       mute;
   logic       force_err;
   logic       sl_ack;
   logic [7:0] sl_regs [2];

   logic [W-1:0] exp_q[$];
   int           checks;
   int           errors;
   logic [1:0]   exp_gnt [9] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00};

   gpio_wb_arbiter #(.AW(1), .DW(8), .TIMEOUT(15)) dut (
      .wb_clk(clk), .wb_rst_n(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
      .grant_o(grant_o), .dbg_state_o(dbg_state)
   );

   // Watchdog-disabled instance sharing the master inputs; its slave never answers.
   gpio_wb_arbiter #(.AW(1), .DW(8), .TIMEOUT(0)) dut_z (
      .wb_clk(clk), .wb_rst_n(rst_n),
      .m0_adr_i(m0_adr), .m0_dat_i(m0_wd), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
      .m0_dat_o(z_m0_dat), .m0_ack_o(z_m0_ack), .m0_err_o(z_m0_err),
      .m1_adr_i(m1_adr), .m1_dat_i(m1_wd), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
      .m1_dat_o(z_m1_dat), .m1_ack_o(z_m1_ack), .m1_err_o(z_m1_err),
      .s_adr_o(z_s_adr), .s_dat_o(z_s_dat), .s_we_o(z_s_we), .s_cyc_o(z_s_cyc), .s_stb_o(z_s_stb),
      .s_dat_i(8'h00), .s_ack_i(1'b0), .s_err_i(1'b0),
      .grant_o(z_grant), .dbg_state_o(z_dbg)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // GPIO-like slave: adr 0 = data out, adr 1 = dir; registered single-cycle ack.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sl_ack     <= 1'b0;
         sl_regs[0] <= 8'h00;
         sl_regs[1] <= 8'h00;
      end else begin
         sl_ack <= !mute && s_cyc_o && s_stb_o && !sl_ack;
         if (!mute && s_cyc_o && s_stb_o && !sl_ack && s_we_o)
            sl_regs[s_adr_o] <= s_dat_o;
      end
   end
   assign s_ack_i = sl_ack;
   assign s_dat_i = (sl_ack && !s_we_o) ? sl_regs[s_adr_o] : 8'h00;
   assign s_err_i = force_err;

   function automatic logic [W-1:0] pk(input logic [1:0] g, input logic a0, input logic e0,
                                        input logic [7:0] d0, input logic a1, input logic e1,
                                        input logic [7:0] d1);
      return {g, a0, e0, d0, a1, e1, d1};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every ack/err presented to a master is matched against exp_q.
   always @(negedge clk) begin
      if (rst_n && (m0_ack_o || m0_err_o || m1_ack_o || m1_err_o)) begin
         logic [W-1:0] act;
         logic [W-1:0] req;
         act = pk(grant_o, m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp actual=%h required=none", act);
         end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
               errors++;
               $display("FAIL resp actual=%h required=%h", act, req);
            end
         end
      end
   end

   task automatic drive(input bit m, input logic cyc, input logic we, input logic adr,
                        input logic [7:0] dat);
      if (m == 1'b0) begin
         m0_cyc = cyc; m0_stb = cyc; m0_we = we; m0_adr = adr; m0_wd = dat;
      end else begin
         m1_cyc = cyc; m1_stb = cyc; m1_we = we; m1_adr = adr; m1_wd = dat;
      end
   endtask

   // One classic single transfer; returns with cyc low for one full cycle.
   task automatic xfer(input bit m, input logic we, input logic adr, input logic [7:0] dat);
      int  n;
      bit  got;
      n   = 0;
      got = 1'b0;
      drive(m, 1'b1, we, adr, dat);
      while (!got && n < 60) begin
         @(negedge clk);
         if (m == 1'b0) got = m0_ack_o | m0_err_o;
         else           got = m1_ack_o | m1_err_o;
         n++;
      end
      if (!got) chk($sformatf("xfer_timeout_m%0d", m), 32'(got), 32'd1);
      @(posedge clk); #1;
      drive(m, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic contend(input logic [7:0] d0, input logic [7:0] d1);
      fork
         xfer(1'b0, 1'b1, 1'b0, d0);
         xfer(1'b1, 1'b1, 1'b0, d1);
      join
   endtask

   initial begin
      int pulses_z;
      checks = 0; errors = 0; mute = 1'b0; force_err = 1'b0;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_grant", 32'(grant_o), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
      chk("rst_s_stb", 32'(s_stb_o), 32'd0);
      @(posedge clk); #1;

      // m0 write A5 then read it back; grant registers one cycle after cyc
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      fork
         xfer(1'b0, 1'b1, 1'b0, 8'hA5);
         begin
            @(negedge clk);
            chk("t1_grant_c0", 32'(grant_o), 32'd0);
            @(negedge clk);
            chk("t1_grant_c1", 32'(grant_o), 32'd1);
            chk("t1_s_cyc_c1", 32'(s_cyc_o), 32'd1);
            chk("t1_s_dat_c1", 32'(s_dat_o), 32'hA5);
            chk("t1_ack_c1", 32'(m0_ack_o), 32'd0);
         end
      join
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00));
      xfer(1'b0, 1'b0, 1'b0, 8'h00);

      // Contention from reset: m0, m1, m0, m1; then after a solo m0, m1 goes first
      do_reset();
      @(posedge clk); #1;
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(pk(2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      fork
         contend(8'h11, 8'h22);
         begin
            for (int i = 0; i < 9; i++) begin
               @(negedge clk);
               chk($sformatf("t2_grant_c%0d", i), 32'(grant_o), 32'(exp_gnt[i]));
            end
         end
      join
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(pk(2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      contend(8'h33, 8'h44);
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      xfer(1'b0, 1'b1, 1'b0, 8'h55);
      exp_q.push_back(pk(2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      contend(8'h66, 8'h77);

      // m1 sets dir to 0F and reads it back; m0 sees zero data
      exp_q.push_back(pk(2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      xfer(1'b1, 1'b1, 1'b1, 8'h0F);
      exp_q.push_back(pk(2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0F));
      xfer(1'b1, 1'b0, 1'b1, 8'h00);

      // Stalled slave: single err pulse on the 16th granted stb cycle, none without watchdog
      mute = 1'b1;
      pulses_z = 0;
      exp_q.push_back(pk(2'b01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk($sformatf("t4_err_k%0d", k), 32'(m0_err_o), 32'(k == 16));
         chk($sformatf("t4_stb_k%0d", k), 32'(s_stb_o), 32'(k != 16));
         if (z_m0_err) pulses_z++;
      end
      chk("t4_nowdog_pulses", 32'(pulses_z), 32'd0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;

      // Slave err passes straight through and restarts the watchdog
      exp_q.push_back(pk(2'b01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(pk(2'b01, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00));
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         force_err = (k == 11);
         @(negedge clk);
         chk($sformatf("t6_err_k%0d", k), 32'(m0_err_o), 32'((k == 11) || (k == 27)));
         if (k == 11) chk("t6_m1_err", 32'(m1_err_o), 32'd0);
      end
      @(posedge clk); #1;
      force_err = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      @(posedge clk); #1;

      // Asynchronous reset while m1 owns the bus
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      @(negedge clk);
      chk("t5_grant_before", 32'(grant_o), 32'd2);
      chk("t5_s_cyc_before", 32'(s_cyc_o), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_grant_async", 32'(grant_o), 32'd0);
      chk("t5_s_cyc_async", 32'(s_cyc_o), 32'd0);
      chk("t5_s_stb_async", 32'(s_stb_o), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      mute = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      exp_q.push_back(pk(2'b01, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
      exp_q.push_back(pk(2'b10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00));
      contend(8'h88, 8'h99);

      repeat (3) @(posedge clk);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
